bullet_fire_arbiter: RTL and testbench

Allocates bullet slots in the 64-entry bullet store for the two player tanks. Each cycle it takes both players' fire requests and picks a winner, alternating between players when both request. It then finds a free slot by next-fit scan and writes one packed 32-bit bullet word into that slot. The bullet store's `allBulletContents` bus feeds the VGA overlay, so this block is the only writer that creates new bullets.

---
 rtl/bullet_fire_arbiter_if.sv | 15 +
 rtl/bullet_fire_arbiter.sv | 129 ++++++++++++
 tb/tb_bullet_fire_arbiter.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/bullet_fire_arbiter_if.sv
// Bullet-store write bus: the arbiter drives the write strobe/slot/word and
// observes the per-slot active flags.
interface bullet_fire_arbiter_if #(
  parameter int MAX_BULLETS = 64
);
  localparam int SW = $clog2(MAX_BULLETS);

  logic                   wr_en;
  logic [SW-1:0]          wr_slot;
  logic [31:0]            wr_data;
  logic [MAX_BULLETS-1:0] slot_busy;

  modport master (output wr_en, wr_slot, wr_data, input slot_busy);
  modport slave  (input wr_en, wr_slot, wr_data, output slot_busy);
endinterface

// File: rtl/bullet_fire_arbiter.sv
// Round-robin fire arbiter with next-fit slot scan into the 64-entry bullet store.
// Optional BULLET_DROP_CNT_EN adds a saturating count of requests dropped on a full store.
module bullet_fire_arbiter #(
  parameter int MAX_BULLETS     = 64,
  parameter int COOLDOWN_FRAMES = 8
) (
  input  logic       clk,
  input  logic       CPU_RESETN,
  input  logic       frame_tick,
  input  logic [1:0] fire_req,
  input  logic [1:0] p_alive,
  input  logic [9:0] p1_x,
  input  logic [9:0] p2_x,
  input  logic [8:0] p1_y,
  input  logic [8:0] p2_y,
  input  logic [1:0] p1_dir,
  input  logic [1:0] p2_dir,
  bullet_fire_arbiter_if.master store,
  output logic [1:0] grant,
`ifdef BULLET_DROP_CNT_EN
  output logic [7:0] drop_cnt,
`endif
  output logic       arb_busy
);
  localparam int SW = $clog2(MAX_BULLETS);
  localparam int CW = $clog2(COOLDOWN_FRAMES + 1);

  typedef enum logic [1:0] {IDLE, SCAN, WRITE} state_t;

  state_t             state, stateNext;
  logic [SW-1:0]      ptr, scanCnt;
  logic               rr;
  logic [1:0][CW-1:0] cool;
  logic [1:0]         elig;
  logic               winner, slotFree, exhausted;
  logic [9:0]         latX;
  logic [8:0]         latY;
  logic [1:0]         latDir;
  logic               latOwner;

  always_comb begin
    elig[0]   = fire_req[0] & p_alive[0] & (cool[0] == '0);
    elig[1]   = fire_req[1] & p_alive[1] & (cool[1] == '0);
    // rr only breaks ties; a lone eligible player wins outright
    winner    = (elig == 2'b11) ? rr : elig[1];
    slotFree  = ~store.slot_busy[ptr];
    exhausted = (scanCnt == SW'(MAX_BULLETS - 1));
  end

  always_comb begin
    stateNext = state;
    unique case (state)
      IDLE:    if (|elig) stateNext = SCAN;
      SCAN: begin
        if (slotFree)       stateNext = WRITE;
        else if (exhausted) stateNext = IDLE;
      end
      WRITE:   stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge CPU_RESETN) begin
    if (!CPU_RESETN) state <= IDLE;
    else             state <= stateNext;
  end

  always_ff @(posedge clk or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      store.wr_en   <= 1'b0;
      store.wr_slot <= '0;
      store.wr_data <= '0;
      grant         <= '0;
      arb_busy      <= 1'b0;
      ptr           <= '0;
      scanCnt       <= '0;
      rr            <= 1'b0;
      cool          <= '0;
      latX          <= '0;
      latY          <= '0;
      latDir        <= '0;
      latOwner      <= 1'b0;
`ifdef BULLET_DROP_CNT_EN
      drop_cnt      <= '0;
`endif
    end else begin
      store.wr_en <= 1'b0;
      grant       <= '0;
      arb_busy    <= (stateNext != IDLE);

      unique case (state)
        IDLE: if (|elig) begin
          latX     <= winner ? p2_x   : p1_x;
          latY     <= winner ? p2_y   : p1_y;
          latDir   <= winner ? p2_dir : p1_dir;
          latOwner <= winner;
          scanCnt  <= '0;
        end
        SCAN: begin
          if (slotFree) begin
            store.wr_en   <= 1'b1;
            store.wr_slot <= ptr;
            store.wr_data <= {latX, latY, latDir, latOwner, 7'd0, 1'b1, 2'd0};
            grant         <= latOwner ? 2'b10 : 2'b01;
          end else begin
            // a full lap advances ptr MAX_BULLETS times, leaving it where it started
            ptr     <= ptr + 1'b1;
            scanCnt <= scanCnt + 1'b1;
`ifdef BULLET_DROP_CNT_EN
            if (exhausted && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
`endif
          end
        end
        WRITE: begin
          rr  <= ~rr;
          ptr <= ptr + 1'b1;
        end
        default: ;
      endcase

      for (int unsigned i = 0; i < 2; i++) begin
        if (state == WRITE && latOwner == 1'(i))
          cool[i] <= CW'(COOLDOWN_FRAMES);
        else if (frame_tick && cool[i] != '0)
          cool[i] <= cool[i] - 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_bullet_fire_arbiter.sv
// Scoreboard bench: directed stimulus pushes expected writes, a negedge monitor checks them.
module tb_bullet_fire_arbiter;
  localparam int MB = 64;
  localparam int CD = 2;

  logic       clk = 1'b0;
  logic       CPU_RESETN;
  logic       frame_tick;
  logic [1:0] fire_req, p_alive;
  logic [9:0] p1_x, p2_x;
  logic [8:0] p1_y, p2_y;
  logic [1:0] p1_dir, p2_dir;
  logic [1:0] grant;
  logic       arb_busy;
`ifdef BULLET_DROP_CNT_EN
  logic [7:0] drop_cnt;
`endif

  always #5 clk = ~clk;

  bullet_fire_arbiter_if #(.MAX_BULLETS(MB)) store ();

  bullet_fire_arbiter #(.MAX_BULLETS(MB), .COOLDOWN_FRAMES(CD)) dut (
    .clk(clk), .CPU_RESETN(CPU_RESETN), .frame_tick(frame_tick),
    .fire_req(fire_req), .p_alive(p_alive),
    .p1_x(p1_x), .p2_x(p2_x), .p1_y(p1_y), .p2_y(p2_y),
    .p1_dir(p1_dir), .p2_dir(p2_dir),
    .store(store), .grant(grant),
`ifdef BULLET_DROP_CNT_EN
    .drop_cnt(drop_cnt),
`endif
    .arb_busy(arb_busy)
  );

  typedef struct {
    logic [5:0]  slot;
    logic [31:0] data;
    logic [1:0]  gnt;
    int unsigned cyc;
    bit          chkCyc;
  } exp_t;

  exp_t        q[$];
  int          compared = 0;
  int          mismatched = 0;
  int unsigned cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] pk(input logic [9:0] x, input logic [8:0] y,
                                     input logic [1:0] d, input logic o);
    return {x, y, d, o, 7'd0, 1'b1, 2'd0};
  endfunction

  task automatic push(input logic [5:0] s, input logic [31:0] d, input logic [1:0] g,
                      input int unsigned c, input bit cc);
    exp_t e;
    e.slot = s; e.data = d; e.gnt = g; e.cyc = c; e.chkCyc = cc;
    q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (CPU_RESETN === 1'b1) begin
      if (store.wr_en) begin
        if (q.size() == 0) begin
          compared++;
          mismatched++;
          $display("FAIL unexpected_write: got slot %0d grant %b, expected no write (cycle %0d)",
                   store.wr_slot, grant, cyc);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("wr_slot", 64'(store.wr_slot), 64'(e.slot));
          chk("wr_data", 64'(store.wr_data), 64'(e.data));
          chk("grant",   64'(grant),         64'(e.gnt));
          if (e.chkCyc) chk("wr_cycle", 64'(cyc), 64'(e.cyc));
        end
      end else if (grant != 2'b00) begin
        compared++;
        mismatched++;
        $display("FAIL stray_grant: got %b without wr_en, expected 00 (cycle %0d)", grant, cyc);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic doReset();
    CPU_RESETN = 1'b0;
    fire_req   = 2'b00;
    frame_tick = 1'b0;
    step(2);
    CPU_RESETN = 1'b1;
    step(1);
  endtask

  task automatic drain(input int limit);
    int n = 0;
    while (q.size() != 0 && n < limit) begin
      step(1);
      n++;
    end
    if (q.size() != 0) begin
      compared++;
      mismatched++;
      $display("FAIL timeout: got %0d writes still pending, expected 0", q.size());
      q.delete();
    end
  endtask

  task automatic chkOutputsZero(input string tag);
    chk({tag, "_wr_en"},    64'(store.wr_en),   64'd0);
    chk({tag, "_wr_slot"},  64'(store.wr_slot), 64'd0);
    chk({tag, "_wr_data"},  64'(store.wr_data), 64'd0);
    chk({tag, "_grant"},    64'(grant),         64'd0);
    chk({tag, "_arb_busy"}, 64'(arb_busy),      64'd0);
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: got no completion, expected finish");
    $fatal(1);
  end

  initial begin
    int unsigned c;
    logic [63:0] one;
    one        = 64'd1;
    CPU_RESETN = 1'b0;
    frame_tick = 1'b0;
    fire_req   = 2'b00;
    p_alive    = 2'b11;
    store.slot_busy = '0;
    p1_x = 10'd100; p1_y = 9'd50;  p1_dir = 2'd1;
    p2_x = 10'd300; p2_y = 9'd200; p2_dir = 2'd2;

    // reset values
    step(1);
    chkOutputsZero("rst");
    doReset();
    chkOutputsZero("post_rst");

    // single P1 shot; inputs change after latch and must not leak into the word
    c = cyc;
    fire_req = 2'b01;
    push(6'd0, pk(10'd100, 9'd50, 2'd1, 1'b0), 2'b01, c + 2, 1'b1);
    step(1);
    fire_req = 2'b00;
    p1_x = 10'd999; p1_dir = 2'd3;
    drain(10);
    p1_x = 10'd100; p1_dir = 2'd1;

    // both held: alternate, then blocked until two frame ticks pass
    doReset();
    c = cyc;
    fire_req = 2'b11;
    push(6'd0, pk(10'd100, 9'd50,  2'd1, 1'b0), 2'b01, c + 2,  1'b1);
    push(6'd1, pk(10'd300, 9'd200, 2'd2, 1'b1), 2'b10, c + 5,  1'b1);
    push(6'd2, pk(10'd100, 9'd50,  2'd1, 1'b0), 2'b01, c + 43, 1'b1);
    push(6'd3, pk(10'd300, 9'd200, 2'd2, 1'b1), 2'b10, c + 46, 1'b1);
    for (int i = 0; i < 50; i++) begin
      frame_tick = (i == 20 || i == 40);
      step(1);
    end
    frame_tick = 1'b0;
    fire_req   = 2'b00;
    drain(5);

    // ten busy probes before the first free slot
    doReset();
    store.slot_busy = 64'h3FF;
    c = cyc;
    fire_req = 2'b10;
    push(6'd10, pk(10'd300, 9'd200, 2'd2, 1'b1), 2'b10, c + 12, 1'b1);
    step(1);
    fire_req = 2'b00;
    drain(20);

    // full store: request dropped after a full lap
    doReset();
    store.slot_busy = '1;
    c = cyc;
    fire_req = 2'b01;
    step(1);
    fire_req = 2'b00;
    step(63);
    chk("full_busy_c64", 64'(arb_busy), 64'd1);
    step(1);
    chk("full_idle_c65", 64'(arb_busy), 64'd0);
`ifdef BULLET_DROP_CNT_EN
    chk("drop_cnt", 64'(drop_cnt), 64'd1);
`endif
    // drop left cool[0]=0 and rr=0: P1 wins the tie, then P2 wraps round to the same slot
    store.slot_busy = ~(one << 5);
    fire_req = 2'b11;
    push(6'd5, pk(10'd100, 9'd50,  2'd1, 1'b0), 2'b01, 0, 1'b0);
    push(6'd5, pk(10'd300, 9'd200, 2'd2, 1'b1), 2'b10, 0, 1'b0);
    drain(200);
    fire_req = 2'b00;

    // dead P1 never granted; P2 refires after its cooldown
    doReset();
    store.slot_busy = '0;
    p_alive = 2'b10;
    c = cyc;
    fire_req = 2'b11;
    push(6'd0, pk(10'd300, 9'd200, 2'd2, 1'b1), 2'b10, c + 2,  1'b1);
    push(6'd1, pk(10'd300, 9'd200, 2'd2, 1'b1), 2'b10, c + 43, 1'b1);
    for (int i = 0; i < 50; i++) begin
      frame_tick = (i == 20 || i == 40);
      step(1);
    end
    frame_tick = 1'b0;
    fire_req   = 2'b00;
    drain(5);
    p_alive = 2'b11;

    // reset in the first SCAN cycle aborts the write and clears rr/ptr
    doReset();
    c = cyc;
    fire_req = 2'b10;
    push(6'd0, pk(10'd300, 9'd200, 2'd2, 1'b1), 2'b10, c + 2, 1'b1);
    step(1);
    fire_req = 2'b00;
    drain(10);
    fire_req = 2'b01;
    step(1);
    CPU_RESETN = 1'b0;
    fire_req   = 2'b00;
    #1;
    chkOutputsZero("abort");
    step(1);
    CPU_RESETN = 1'b1;
    step(2);
    chkOutputsZero("abort_after");
    c = cyc;
    fire_req = 2'b11;
    push(6'd0, pk(10'd100, 9'd50, 2'd1, 1'b0), 2'b01, c + 2, 1'b1);
    step(1);
    fire_req = 2'b00;
    drain(10);
    step(5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
